alu_serial: RTL and testbench

ALU_SERIAL -- requirements
Module: alu_serial

---
 rtl/alu_serial_pkg.sv | 20 ++
 rtl/alu_serial_alu_1bit.sv | 43 ++++
 rtl/alu_serial.sv | 105 ++++++++++
 tb/tb_alu_serial.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_serial_pkg.sv
// Shared definitions for the bit-serial ALU: op codes and controller states.
// Optional signed-overflow output is enabled by defining ALU_SERIAL_OVF_EN.
package alu_serial_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic is_arith(input logic [1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_serial_alu_1bit.sv
// One-bit ALU slice: full adder with B inversion for SUB, plus AND/OR.
// Logic ops report a zero carry so the serial carry chain stays clean.
module alu_1bit
    import alu_serial_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [1:0] op,
    output logic       r,
    output logic       cout
);

    logic bx;
    logic sum;
    logic cry;

    assign bx  = (op == OP_SUB) ? ~b : b;
    assign sum = a ^ bx ^ cin;
    assign cry = (a & bx) | (cin & (a ^ bx));

    always_comb begin
        r    = 1'b0;
        cout = 1'b0;
        unique case (1'b1)
            (op == OP_ADD): begin
                r    = sum;
                cout = cry;
            end
            (op == OP_SUB): begin
                r    = sum;
                cout = cry;
            end
            (op == OP_AND): r = a & b;
            (op == OP_OR):  r = a | b;
            default: begin
                r    = 1'b0;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_serial.sv
// Bit-serial ALU, LSB first, one alu_1bit slice per cycle.
// Define ALU_SERIAL_OVF_EN to add the overflow_flag output.
module alu_serial
    import alu_serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op_code,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_flag,
    output logic             zero_flag
`ifdef ALU_SERIAL_OVF_EN
    ,
    output logic             overflow_flag
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] r_sh;
    logic [1:0]       op_q;
    logic [CW-1:0]    cnt;
    logic             cy;
    logic             slice_r;
    logic             slice_c;
    logic [WIDTH-1:0] r_next;

    alu_1bit u_slice (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (cy),
        .op   (op_q),
        .r    (slice_r),
        .cout (slice_c)
    );

    // Result bits enter at the MSB so after WIDTH cycles bit 0 sits at LSB
    assign r_next = {slice_r, r_sh};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            carry_flag <= 1'b0;
            zero_flag  <= 1'b1;
            a_sh       <= '0;
            b_sh       <= '0;
            r_sh       <= '0;
            op_q       <= OP_ADD;
            cnt        <= '0;
            cy         <= 1'b0;
`ifdef ALU_SERIAL_OVF_EN
            overflow_flag <= 1'b0;
`endif
        end else begin
            busy <= (state == ST_SHIFT);
            done <= (state == ST_DONE);
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sh  <= a_in;
                        b_sh  <= b_in;
                        op_q  <= op_code;
                        cnt   <= '0;
                        cy    <= (op_code == OP_SUB);
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    r_sh <= r_next[WIDTH-1:1];
                    cy   <= slice_c;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state      <= ST_DONE;
                        result     <= r_next;
                        carry_flag <= slice_c;
                        zero_flag  <= (r_next == '0);
`ifdef ALU_SERIAL_OVF_EN
                        // cy holds the carry into the MSB on the last bit
                        overflow_flag <= is_arith(op_q) & (cy ^ slice_c);
`endif
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial.sv
// Self-checking bench for alu_serial (WIDTH = 8) against an arithmetic model.
// Overflow checks are compiled in when ALU_SERIAL_OVF_EN is defined.
module tb_alu_serial;
    import alu_serial_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start = 1'b0;
    logic [1:0]   op_code = 2'b00;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_flag;
    logic         zero_flag;
`ifdef ALU_SERIAL_OVF_EN
    logic         overflow_flag;
`endif

    int errors = 0;
    int checks = 0;

    alu_serial #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op_code    (op_code),
        .a_in       (a_in),
        .b_in       (b_in),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag)
`ifdef ALU_SERIAL_OVF_EN
        ,
        .overflow_flag (overflow_flag)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values
    task automatic model(input logic [1:0] op, input int a, input int b,
                         output int r, output int c, output int v);
        int mask;
        int msb;
        mask = (1 << W) - 1;
        msb  = 1 << (W - 1);
        r = 0;
        c = 0;
        v = 0;
        case (op)
            OP_ADD: begin
                r = (a + b) & mask;
                c = ((a + b) > mask) ? 1 : 0;
                v = (((a & msb) == (b & msb)) &&
                     ((r & msb) != (a & msb))) ? 1 : 0;
            end
            OP_SUB: begin
                r = (a - b) & mask;
                c = (a >= b) ? 1 : 0;
                v = (((a & msb) != (b & msb)) &&
                     ((r & msb) != (a & msb))) ? 1 : 0;
            end
            OP_AND: r = a & b;
            default: r = a | b;
        endcase
    endtask

    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit noise, input bit rel);
        int r, c, v;
        int lat;
        int pulses;
        int busy_bad;
        int hold_bad;
        logic [W-1:0] prev_r;
        logic prev_c, prev_z;
        lat = -1;
        pulses = 0;
        busy_bad = 0;
        hold_bad = 0;
        model(op, int'(a), int'(b), r, c, v);
        @(negedge clk);
        start   = 1'b1;
        op_code = op;
        a_in    = a;
        b_in    = b;
        if (rel) rst_n = 1'b1;
        prev_r = result;
        prev_c = carry_flag;
        prev_z = zero_flag;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (busy !== 1'b0) busy_bad++;
        for (int k = 1; k <= W + 6; k++) begin
            @(posedge clk);
            #1;
            if (noise && k >= 2 && k <= 4) begin
                start   = 1'b1;
                op_code = 2'($urandom_range(3));
                a_in    = W'($urandom);
                b_in    = W'($urandom);
            end else begin
                start = 1'b0;
            end
            if (busy !== (k <= W)) busy_bad++;
            if (k <= W - 1 && (result !== prev_r ||
                carry_flag !== prev_c || zero_flag !== prev_z))
                hold_bad++;
            if (done === 1'b1) begin
                pulses++;
                if (lat < 0) lat = k;
            end
            if (!noise && done === 1'b1) break;
        end
        check({tag, " latency"}, lat, W + 1);
        check({tag, " pulses"}, pulses, 1);
        check({tag, " busy"}, busy_bad, 0);
        check({tag, " hold"}, hold_bad, 0);
        check({tag, " result"}, result, r);
        check({tag, " carry"}, carry_flag, c);
        check({tag, " zero"}, zero_flag, (r == 0) ? 1 : 0);
`ifdef ALU_SERIAL_OVF_EN
        check({tag, " ovf"}, overflow_flag, v);
`endif
    endtask

    initial begin
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #3;
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst result", result, 0);
        check("rst carry", carry_flag, 0);
        check("rst zero", zero_flag, 1);
`ifdef ALU_SERIAL_OVF_EN
        check("rst ovf", overflow_flag, 0);
`endif
        repeat (2) @(posedge clk);

        run_op("add_ff_01", OP_ADD, 8'hFF, 8'h01, 1'b0, 1'b1);
        run_op("sub_05_07", OP_SUB, 8'h05, 8'h07, 1'b0, 1'b0);
        run_op("sub_07_05", OP_SUB, 8'h07, 8'h05, 1'b0, 1'b0);
        run_op("and_f0_3c", OP_AND, 8'hF0, 8'h3C, 1'b0, 1'b0);
        run_op("or_f0_0c", OP_OR, 8'hF0, 8'h0C, 1'b0, 1'b0);
        run_op("add_7f_01", OP_ADD, 8'h7F, 8'h01, 1'b0, 1'b0);
        run_op("sub_80_01", OP_SUB, 8'h80, 8'h01, 1'b0, 1'b0);
        run_op("add_01_01", OP_ADD, 8'h01, 8'h01, 1'b0, 1'b0);
        run_op("add_noise", OP_ADD, 8'h3A, 8'hC5, 1'b1, 1'b0);
        run_op("or_nz", OP_OR, 8'h21, 8'h84, 1'b0, 1'b0);

        // Reset in the middle of an operation at bit cycle 4
        @(negedge clk);
        start   = 1'b1;
        op_code = OP_ADD;
        a_in    = 8'h12;
        b_in    = 8'h34;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        check("midrst result", result, 0);
        check("midrst zero", zero_flag, 1);
        check("midrst carry", carry_flag, 0);
        repeat (2) @(posedge clk);
        #1;
        check("midrst hold done", done, 0);
        run_op("post_rst", OP_ADD, 8'h55, 8'h0A, 1'b0, 1'b1);

        for (int i = 0; i < 24; i++) begin
            run_op("rand", 2'($urandom_range(3)), W'($urandom),
                   W'($urandom), 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
